// File: rtl/oric_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// oric_sdram_arbiter
//
// Shares one toggle-handshake SDRAM port between the Oric CPU/ULA RAM bus
// and a DMA requester (disk-image / FDC sector buffer / loader).
//
// The CPU's level-style cs/oe/we bus is turned into discrete SDRAM
// transactions. The CPU always wins arbitration. Each side has a 1-deep
// pending slot.
//
// Ports
//   clk_sys, reset        system clock, synchronous active-high reset
//   cpu_cs/oe/we          CPU RAM select / read enable / write enable
//   cpu_addr, cpu_din     CPU byte address and write data
//   cpu_dout              last CPU read byte (held)
//   dma_req, dma_we       one-cycle DMA request pulse, write flag
//   dma_addr, dma_din     DMA byte address and write data
//   dma_dout, dma_ack     DMA read byte, valid with the one-cycle dma_ack
//   busy                  transaction outstanding or a slot pending
//   err_timeout           sticky, set when the SDRAM never acknowledged
//   sd_req/sd_ack         request/acknowledge toggles to/from the SDRAM
//   sd_a, sd_ds           word address, byte-lane strobes {hi,lo}
//   sd_we, sd_d, sd_q     write flag, write data, read data
// ---------------------------------------------------------------------------
module oric_sdram_arbiter #(
  parameter int                ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] CPU_BASE = '0,
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cpu_cs,
  input  logic              cpu_oe,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_din,
  output logic [7:0]        dma_dout,
  output logic              dma_ack,
  output logic              busy,
  output logic              err_timeout,
  output logic              sd_req,
  input  logic              sd_ack,
  output logic [ADDR_W-2:0] sd_a,
  output logic [1:0]        sd_ds,
  output logic              sd_we,
  output logic [15:0]       sd_d,
  input  logic [15:0]       sd_q
);

  // Counter holds 0..TIMEOUT-1; expiry is detected on the last value.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_WAIT = 2'd1,
    ST_DMA_WAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // CPU bus edge detection
  logic        r_rd_prev;
  logic        r_wr_prev;
  logic [15:0] r_addr_prev;

  // Pending slots
  logic              r_cpu_valid;
  logic              r_cpu_we;
  logic [ADDR_W-1:0] r_cpu_addr;
  logic [7:0]        r_cpu_din;
  logic              r_dma_valid;
  logic              r_dma_we;
  logic [ADDR_W-1:0] r_dma_addr;
  logic [7:0]        r_dma_din;

  // Current transaction
  logic             r_cur_a0;
  logic             r_cur_we;
  logic [CNT_W-1:0] r_tmo_cnt;

  // Output registers
  logic              r_sd_req;
  logic [ADDR_W-2:0] r_sd_a;
  logic [1:0]        r_sd_ds;
  logic              r_sd_we;
  logic [15:0]       r_sd_d;
  logic [7:0]        r_cpu_dout;
  logic [7:0]        r_dma_dout;
  logic              r_dma_ack;
  logic              r_err_timeout;

  // Combinational helpers
  logic              w_rd;
  logic              w_wr;
  logic              w_cpu_event;
  logic [ADDR_W-1:0] w_cpu_eff;
  logic              w_dma_accept;
  logic              w_sd_idle;
  logic              w_issue_cpu;
  logic              w_issue_dma;
  logic              w_done;
  logic              w_timeout;
  logic [ADDR_W-1:0] w_iss_addr;
  logic              w_iss_we;
  logic [7:0]        w_iss_din;
  logic [15:0]       w_wr_word;
  logic [7:0]        w_rd_byte;

  assign w_rd      = cpu_cs & cpu_oe;
  assign w_wr      = cpu_cs & cpu_we;
  assign w_cpu_eff = CPU_BASE + ADDR_W'(cpu_addr);

  // New CPU request: rising read strobe, rising write strobe, or the address
  // moving while the read strobe stays asserted (ULA/CPU back-to-back reads).
  assign w_cpu_event = (w_rd & ~r_rd_prev) |
                       (w_wr & ~r_wr_prev) |
                       (w_rd & r_rd_prev & (cpu_addr != r_addr_prev));

  // A DMA request is dropped while its slot is full or its access is in flight.
  assign w_dma_accept = dma_req & ~r_dma_valid & (r_state != ST_DMA_WAIT);

  assign w_sd_idle = (sd_ack == r_sd_req);

  // Source selection for the issued transaction
  assign w_iss_addr = w_issue_cpu ? r_cpu_addr : r_dma_addr;
  assign w_iss_we   = w_issue_cpu ? r_cpu_we   : r_dma_we;
  assign w_iss_din  = w_issue_cpu ? r_cpu_din  : r_dma_din;

  // Write byte replicated onto both lanes; the strobe picks the real one.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign w_wr_word[gi*8 +: 8] = w_iss_din;
  end

  assign w_rd_byte = r_cur_a0 ? sd_q[15:8] : sd_q[7:0];

  // FSM state register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and control strobes
  always_comb begin
    w_state_next = r_state;
    w_issue_cpu  = 1'b0;
    w_issue_dma  = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sd_idle) begin
          if (r_cpu_valid) begin
            w_issue_cpu  = 1'b1;
            w_state_next = ST_CPU_WAIT;
          end else if (r_dma_valid) begin
            w_issue_dma  = 1'b1;
            w_state_next = ST_DMA_WAIT;
          end
        end
      end
      ST_CPU_WAIT, ST_DMA_WAIT: begin
        if (w_sd_idle) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath, slots and output registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_rd_prev     <= 1'b0;
      r_wr_prev     <= 1'b0;
      r_addr_prev   <= '0;
      r_cpu_valid   <= 1'b0;
      r_cpu_we      <= 1'b0;
      r_cpu_addr    <= '0;
      r_cpu_din     <= '0;
      r_dma_valid   <= 1'b0;
      r_dma_we      <= 1'b0;
      r_dma_addr    <= '0;
      r_dma_din     <= '0;
      r_cur_a0      <= 1'b0;
      r_cur_we      <= 1'b0;
      r_tmo_cnt     <= '0;
      r_sd_req      <= 1'b0;
      r_sd_a        <= '0;
      r_sd_ds       <= 2'b00;
      r_sd_we       <= 1'b0;
      r_sd_d        <= '0;
      r_cpu_dout    <= '0;
      r_dma_dout    <= '0;
      r_dma_ack     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_rd_prev   <= w_rd;
      r_wr_prev   <= w_wr;
      r_addr_prev <= cpu_addr;
      r_dma_ack   <= 1'b0;

      // Clear on issue first, so an event in the same cycle refills the slot.
      if (w_issue_cpu) begin
        r_cpu_valid <= 1'b0;
      end
      if (w_cpu_event) begin
        r_cpu_valid <= 1'b1;
        r_cpu_we    <= cpu_we;
        r_cpu_addr  <= w_cpu_eff;
        r_cpu_din   <= cpu_din;
      end

      if (w_issue_dma) begin
        r_dma_valid <= 1'b0;
      end
      if (w_dma_accept) begin
        r_dma_valid <= 1'b1;
        r_dma_we    <= dma_we;
        r_dma_addr  <= dma_addr;
        r_dma_din   <= dma_din;
      end

      if (w_issue_cpu || w_issue_dma) begin
        r_sd_req  <= ~r_sd_req;
        r_sd_a    <= w_iss_addr[ADDR_W-1:1];
        r_sd_ds   <= w_iss_we ? (w_iss_addr[0] ? 2'b10 : 2'b01) : 2'b11;
        r_sd_we   <= w_iss_we;
        r_sd_d    <= w_wr_word;
        r_cur_a0  <= w_iss_addr[0];
        r_cur_we  <= w_iss_we;
        r_tmo_cnt <= '0;
      end else if (r_state != ST_IDLE && !w_done && !w_timeout) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end

      if (w_done) begin
        if (!r_cur_we) begin
          if (r_state == ST_CPU_WAIT) begin
            r_cpu_dout <= w_rd_byte;
          end else begin
            r_dma_dout <= w_rd_byte;
          end
        end
        if (r_state == ST_DMA_WAIT) begin
          r_dma_ack <= 1'b1;
        end
      end

      // Abort: realign the toggle pair so the next request starts clean.
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
        r_sd_req      <= sd_ack;
        if (r_state == ST_DMA_WAIT) begin
          r_dma_ack  <= 1'b1;
          r_dma_dout <= 8'hFF;
        end
      end
    end
  end

  assign busy        = (r_state != ST_IDLE) | r_cpu_valid | r_dma_valid;
  assign sd_req      = r_sd_req;
  assign sd_a        = r_sd_a;
  assign sd_ds       = r_sd_ds;
  assign sd_we       = r_sd_we;
  assign sd_d        = r_sd_d;
  assign cpu_dout    = r_cpu_dout;
  assign dma_dout    = r_dma_dout;
  assign dma_ack     = r_dma_ack;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_oric_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oric_sdram_arbiter
//
// Directed bench for oric_sdram_arbiter. A small SDRAM responder answers each
// request toggle after a programmable delay; a monitor logs every issued
// transaction and every dma_ack pulse. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_oric_sdram_arbiter;

  logic        clk_sys;
  logic        reset;
  logic        cpu_cs;
  logic        cpu_oe;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        dma_req;
  logic        dma_we;
  logic [23:0] dma_addr;
  logic [7:0]  dma_din;
  logic [7:0]  dma_dout;
  logic        dma_ack;
  logic        busy;
  logic        err_timeout;
  logic        sd_req;
  logic        sd_ack;
  logic [22:0] sd_a;
  logic [1:0]  sd_ds;
  logic        sd_we;
  logic [15:0] sd_d;
  logic [15:0] sd_q;

  oric_sdram_arbiter #(
    .ADDR_W   (24),
    .CPU_BASE (24'h000000),
    .TIMEOUT  (255)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .cpu_cs      (cpu_cs),
    .cpu_oe      (cpu_oe),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_din     (dma_din),
    .dma_dout    (dma_dout),
    .dma_ack     (dma_ack),
    .busy        (busy),
    .err_timeout (err_timeout),
    .sd_req      (sd_req),
    .sd_ack      (sd_ack),
    .sd_a        (sd_a),
    .sd_ds       (sd_ds),
    .sd_we       (sd_we),
    .sd_d        (sd_d),
    .sd_q        (sd_q)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  int passes = 0;
  int checks = 0;

  // SDRAM responder
  int          ack_delay = 5;
  bit          ack_en    = 1'b1;
  logic [15:0] q_val     = 16'h0000;
  int          ack_cnt   = 0;

  initial begin
    sd_ack = 1'b0;
    sd_q   = 16'h0000;
  end

  always @(negedge clk_sys) begin
    if (reset) begin
      sd_ack  = 1'b0;
      ack_cnt = 0;
    end else if (ack_en && (sd_req != sd_ack)) begin
      ack_cnt = ack_cnt + 1;
      if (ack_cnt >= ack_delay) begin
        sd_q    = q_val;
        sd_ack  = ~sd_ack;
        ack_cnt = 0;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // Transaction monitor
  int          toggles  = 0;
  int          dma_acks = 0;
  logic        prev_req = 1'b0;
  logic [22:0] log_a  [16];
  logic [1:0]  log_ds [16];
  logic        log_we [16];
  logic [15:0] log_d  [16];
  logic [7:0]  last_dma_dout = 8'h00;

  always @(negedge clk_sys) begin
    if (!reset && (sd_req != prev_req)) begin
      if (toggles < 16) begin
        log_a[toggles]  = sd_a;
        log_ds[toggles] = sd_ds;
        log_we[toggles] = sd_we;
        log_d[toggles]  = sd_d;
      end
      $display("txn %0d: a=%06h ds=%b we=%b d=%04h", toggles, sd_a, sd_ds, sd_we, sd_d);
      toggles = toggles + 1;
    end
    prev_req = sd_req;
    if (!reset && dma_ack) begin
      dma_acks      = dma_acks + 1;
      last_dma_dout = dma_dout;
      $display("dma_ack %0d: dout=%02h", dma_acks, dma_dout);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_sd_req"},   32'(sd_req),      32'h0);
    chk({pfx, "_sd_we"},    32'(sd_we),       32'h0);
    chk({pfx, "_sd_a"},     32'(sd_a),        32'h0);
    chk({pfx, "_sd_ds"},    32'(sd_ds),       32'h0);
    chk({pfx, "_sd_d"},     32'(sd_d),        32'h0);
    chk({pfx, "_cpu_dout"}, 32'(cpu_dout),    32'h0);
    chk({pfx, "_dma_dout"}, 32'(dma_dout),    32'h0);
    chk({pfx, "_dma_ack"},  32'(dma_ack),     32'h0);
    chk({pfx, "_busy"},     32'(busy),        32'h0);
    chk({pfx, "_err"},      32'(err_timeout), 32'h0);
  endtask

  int tog_snap;
  int ack_snap;

  initial begin
    reset    = 1'b1;
    cpu_cs   = 1'b0;
    cpu_oe   = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_din  = 8'h00;
    dma_req  = 1'b0;
    dma_we   = 1'b0;
    dma_addr = 24'h000000;
    dma_din  = 8'h00;
    tick(3);
    chk_reset("rst");
    reset = 1'b0;
    tick(2);

    // 1: CPU read of odd address, ack after 5 cycles
    q_val     = 16'hAB12;
    ack_delay = 5;
    cpu_addr  = 16'h1235;
    cpu_cs    = 1'b1;
    cpu_oe    = 1'b1;
    tick(1);
    chk("rd1_lat_no_toggle", 32'(sd_req), 32'h0);
    chk("rd1_busy_pending",  32'(busy),   32'h1);
    tick(1);
    chk("rd1_lat_toggle", 32'(sd_req), 32'h1);
    tick(20);
    chk("rd1_toggles",  32'(toggles),   32'd1);
    chk("rd1_sd_a",     32'(log_a[0]),  32'h091A);
    chk("rd1_sd_ds",    32'(log_ds[0]), 32'h3);
    chk("rd1_sd_we",    32'(log_we[0]), 32'h0);
    chk("rd1_cpu_dout", 32'(cpu_dout),  32'hAB);
    chk("rd1_busy",     32'(busy),      32'h0);
    tick(10);
    chk("rd1_hold_no_toggle", 32'(toggles), 32'd1);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    tick(3);

    // 2: CPU write to even address
    cpu_addr = 16'h0400;
    cpu_din  = 8'h5A;
    cpu_we   = 1'b1;
    cpu_cs   = 1'b1;
    tick(20);
    chk("wr_toggles",  32'(toggles),   32'd2);
    chk("wr_sd_we",    32'(log_we[1]), 32'h1);
    chk("wr_sd_ds",    32'(log_ds[1]), 32'h1);
    chk("wr_sd_d",     32'(log_d[1]),  32'h5A5A);
    chk("wr_sd_a",     32'(log_a[1]),  32'h0200);
    chk("wr_cpu_dout", 32'(cpu_dout),  32'hAB);
    cpu_cs = 1'b0;
    cpu_we = 1'b0;
    tick(3);

    // 3: held read, address steps 0x2000 -> 0x2001, ack after 3 cycles
    ack_delay = 3;
    q_val     = 16'hC3D4;
    cpu_addr  = 16'h2000;
    cpu_cs    = 1'b1;
    cpu_oe    = 1'b1;
    tick(10);
    chk("step_first_byte", 32'(cpu_dout), 32'hD4);
    chk("step_toggles1",   32'(toggles),  32'd3);
    cpu_addr = 16'h2001;
    tick(10);
    chk("step_toggles2",    32'(toggles),  32'd4);
    chk("step_sd_a",        32'(log_a[3]), 32'h1000);
    chk("step_second_byte", 32'(cpu_dout), 32'hC3);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    tick(3);

    // 4: DMA read and CPU read in the same cycle
    q_val    = 16'h7E81;
    cpu_addr = 16'h3000;
    cpu_cs   = 1'b1;
    cpu_oe   = 1'b1;
    dma_addr = 24'h010003;
    dma_we   = 1'b0;
    dma_req  = 1'b1;
    tick(1);
    dma_req = 1'b0;
    tick(15);
    chk("sim_toggles",  32'(toggles),       32'd6);
    chk("sim_cpu_first",32'(log_a[4]),      32'h1800);
    chk("sim_dma_sd_a", 32'(log_a[5]),      32'h8001);
    chk("sim_dma_ds",   32'(log_ds[5]),     32'h3);
    chk("sim_dma_acks", 32'(dma_acks),      32'd1);
    chk("sim_dma_dout", 32'(last_dma_dout), 32'h7E);
    chk("sim_cpu_dout", 32'(cpu_dout),      32'h81);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    tick(3);

    // 5: DMA read never acknowledged -> timeout after 255 cycles
    ack_en   = 1'b0;
    dma_addr = 24'h000010;
    dma_req  = 1'b1;
    tick(1);
    dma_req = 1'b0;
    tick(1);
    chk("tmo_req_out", 32'(sd_req ^ sd_ack), 32'h1);
    tick(254);
    chk("tmo_not_yet_err",  32'(err_timeout), 32'h0);
    chk("tmo_not_yet_busy", 32'(busy),        32'h1);
    tick(1);
    chk("tmo_err",      32'(err_timeout),     32'h1);
    chk("tmo_dma_ack",  32'(dma_ack),         32'h1);
    chk("tmo_dma_dout", 32'(dma_dout),        32'hFF);
    chk("tmo_idle",     32'(busy),            32'h0);
    chk("tmo_realign",  32'(sd_req ^ sd_ack), 32'h0);
    tick(1);
    chk("tmo_ack_pulse", 32'(dma_ack),  32'h0);
    chk("tmo_dma_acks",  32'(dma_acks), 32'd2);
    ack_en   = 1'b1;
    q_val    = 16'h1122;
    cpu_addr = 16'h0002;
    cpu_cs   = 1'b1;
    cpu_oe   = 1'b1;
    tick(15);
    chk("post_tmo_cpu_dout", 32'(cpu_dout),    32'h22);
    chk("post_tmo_sticky",   32'(err_timeout), 32'h1);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    tick(3);

    // 6: reset while a CPU read is outstanding
    ack_delay = 5;
    q_val     = 16'h9988;
    cpu_addr  = 16'h0100;
    cpu_cs    = 1'b1;
    cpu_oe    = 1'b1;
    tick(2);
    chk("rst_in_wait", 32'(sd_req ^ sd_ack), 32'h1);
    reset  = 1'b1;
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    tick(1);
    chk_reset("midrst");
    reset    = 1'b0;
    ack_snap = dma_acks;
    tog_snap = toggles;
    tick(12);
    chk("midrst_cpu_dout", 32'(cpu_dout), 32'h0);
    chk("midrst_no_ack",   32'(dma_acks), 32'(ack_snap));
    chk("midrst_no_req",   32'(toggles),  32'(tog_snap));
    chk("midrst_busy",     32'(busy),     32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
